result_bram_writer: RTL

Write-back engine at the output of the MAC array. Captures the per-lane accumulator results (`acc_out_0..3` / `valid_out`), which arrive skewed across lanes by the systolic pipeline, and realigns them in per-lane FIFOs. It packs one aligned result vector into a single `N_MACS*ACC_W`-bit word and writes it to an output BRAM through a synchronous write port. It is the writer counterpart to the weight and input BRAM readers: it lays results out in the same packed format as the weight BRAM word.

---
 rtl/result_bram_writer_if.sv | 13 +
 rtl/result_bram_writer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/result_bram_writer_if.sv
// Synchronous BRAM write port driven by result_bram_writer.
interface result_bram_writer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [DATA_W-1:0] bram_din;

    modport master (output bram_addr, bram_en, bram_we, bram_din);
    modport slave  (input  bram_addr, bram_en, bram_we, bram_din);
endinterface

// File: rtl/result_bram_writer.sv
// MAC-array write-back: per-lane deskew FIFOs, packs one aligned vector per BRAM word.
// Optional RESULT_WB_RELU_EN clamps negative lane values to zero at pack time.
module result_lane_fifo #(
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [ACC_W-1:0] din,
    output logic             empty,
    output logic             drop,
    output logic [ACC_W-1:0] head
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ACC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wp, rp;
    logic             full, accept;

    assign empty  = wp == rp;
    assign full   = (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
    // a full FIFO still takes a sample when the same edge pops it
    assign accept = push && !clr && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accept) wp <= wp + 1'b1;
            if (pop)    rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wp[PTR_W-1:0]] <= din;
    end

`ifdef RESULT_WB_RELU_EN
    assign head = mem[rp[PTR_W-1:0]][ACC_W-1] ? '0 : mem[rp[PTR_W-1:0]];
`else
    assign head = mem[rp[PTR_W-1:0]];
`endif
endmodule

module result_bram_writer #(
    parameter int ACC_W      = 16,
    parameter int N_MACS     = 4,
    parameter int MEM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MEM_DEPTH)-1:0]   base_addr,
    input  logic [$clog2(MEM_DEPTH):0]     num_words,
    input  logic signed [ACC_W-1:0]        acc_in_0,
    input  logic signed [ACC_W-1:0]        acc_in_1,
    input  logic signed [ACC_W-1:0]        acc_in_2,
    input  logic signed [ACC_W-1:0]        acc_in_3,
    input  logic [N_MACS-1:0]              valid_in,
    result_bram_writer_if.master           bram,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);
    localparam int         ADDR_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     state;
    logic [ADDR_W-1:0]              wr_addr;
    logic [ADDR_W:0]                num_q, wr_cnt, cnt_nxt;
    logic [N_MACS-1:0][ACC_W-1:0]   acc_in, head;
    logic [N_MACS-1:0]              empty, drop;
    logic                           run, clr, pop;

    assign acc_in  = {acc_in_3, acc_in_2, acc_in_1, acc_in_0};
    assign run     = state == S_RUN;
    assign clr     = (state == S_IDLE) && start;
    assign pop     = run && ~|empty;
    assign cnt_nxt = wr_cnt + 1'b1;

    for (genvar i = 0; i < N_MACS; i++) begin : g_lane
        result_lane_fifo #(.ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .push  (run && valid_in[i]),
            .pop   (pop),
            .din   (acc_in[i]),
            .empty (empty[i]),
            .drop  (drop[i]),
            .head  (head[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            wr_addr        <= '0;
            num_q          <= '0;
            wr_cnt         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_en   <= 1'b0;
            bram.bram_we   <= 1'b0;
            bram.bram_din  <= '0;
        end else begin
            bram.bram_en <= 1'b0;
            bram.bram_we <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    wr_addr  <= base_addr;
                    num_q    <= num_words;
                    wr_cnt   <= '0;
                    overflow <= 1'b0;
                    if (num_words == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (|drop) overflow <= 1'b1;
                    if (pop) begin
                        bram.bram_en   <= 1'b1;
                        bram.bram_we   <= 1'b1;
                        bram.bram_addr <= wr_addr;
                        bram.bram_din  <= head;
                        wr_addr        <= (wr_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : wr_addr + 1'b1;
                        wr_cnt         <= cnt_nxt;
                        if (cnt_nxt == num_q) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // busy drops together with the done pulse
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
